// File: rtl/booth_seq_ctrl_if.sv
// Handshake and data bundle between the operand/result PIOs and booth_seq_ctrl.
//   start, abort               : request and cancel strobes (master -> slave)
//   multiplicand, multiplier   : signed WIDTH-bit operands (master -> slave)
//   busy, done                 : operation in progress / one-cycle completion pulse
//   product                    : signed 2*WIDTH-bit held result (slave -> master)
interface booth_seq_ctrl_if #(
  parameter int unsigned WIDTH = 6
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, abort, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, abort, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : booth_seq_ctrl_if.slave (start/abort/operands in, busy/done/product out)
// A start accepted in IDLE is followed by WIDTH RUN cycles and one FIN cycle; the product
// register updates on the FIN edge and done pulses for the following cycle.
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CNT_W = 3
) (
  input logic            clk,
  input logic            reset,
  booth_seq_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]         state_q, state_d;
  // A and M carry one extra bit so M = -2**(WIDTH-1) cannot overflow on subtraction.
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    unique case ({q_q[0], qm1_q})
      2'b10:   sum = a_q - m_q;
      2'b01:   sum = a_q + m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        // abort is ignored here, so start+abort together still launches.
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          qm1_d   = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = CNT_W'(WIDTH);
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          // Arithmetic right shift of {A,Q,Q-1} applied to the add/sub result.
          a_d   = {sum[WIDTH], sum[WIDTH:1]};
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          qm1_d = q_q[0];
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!bus.abort) begin
          product_d = {a_q[WIDTH-1:0], q_q};
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl at default sizing (WIDTH=6, 12-bit product).
module tb_booth_seq_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  booth_seq_ctrl_if #(.WIDTH(6)) bus ();

  booth_seq_ctrl #(
    .WIDTH(6),
    .CNT_W(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation and watch 12 cycles starting with the cycle after the start edge.
  task automatic do_mul(input logic [5:0] m, input logic [5:0] q, input logic ab,
                        output int busy_cnt, output int done_cnt, output int done_idx,
                        output logic [11:0] prod, output logic busy_at_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = ab;
    bus.multiplicand = m;
    bus.multiplier = q;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.multiplicand = 6'h15;
    bus.multiplier = 6'h2A;
    busy_cnt = 0;
    done_cnt = 0;
    done_idx = -1;
    prod = 12'hBAD;
    busy_at_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_idx = i;
        prod = bus.product;
        busy_at_done = bus.busy;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_case(input string tag, input logic [5:0] m, input logic [5:0] q,
                          input logic ab, input logic [11:0] exp_prod);
    int bc, dc, di;
    logic [11:0] p;
    logic bd;
    do_mul(m, q, ab, bc, dc, di, p, bd);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd7);
    chk({tag, "_done_cycles"}, 32'(dc), 32'd1);
    chk({tag, "_done_latency"}, 32'(di), 32'd7);
    chk({tag, "_busy_at_done"}, 32'(bd), 32'd0);
    chk({tag, "_product"}, 32'(p), 32'(exp_prod));
    chk({tag, "_product_held"}, 32'(bus.product), 32'(exp_prod));
  endtask

  initial begin
    int nd;
    int d_idx [2];
    logic [11:0] d_prod [2];
    logic [11:0] mid_prod;
    int cnt;

    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;

    // Reset state, with start requested while reset is held.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    run_case("m3_qm2", 6'd3, 6'h3E, 1'b0, 12'hFFA);
    run_case("m32_q32", 6'h20, 6'h20, 1'b0, 12'h400);
    run_case("m31_qm32", 6'd31, 6'h20, 1'b0, 12'hC20);
    run_case("m0_qm17", 6'd0, 6'h2F, 1'b0, 12'h000);
    // start and abort together in IDLE: start wins.
    run_case("start_abort", 6'h3F, 6'h3F, 1'b1, 12'h001);

    // Back-to-back with start held high; operands change during the first operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 6'd5;
    bus.multiplier = 6'd7;
    @(negedge clk);
    @(negedge clk);
    bus.multiplicand = 6'd2;
    bus.multiplier = 6'd2;
    nd = 0;
    d_idx[0] = -1;
    d_idx[1] = -1;
    d_prod[0] = 12'hBAD;
    d_prod[1] = 12'hBAD;
    mid_prod = 12'hBAD;
    for (int i = 1; i < 30; i++) begin
      if (i == 10) mid_prod = bus.product;
      if (bus.done === 1'b1 && nd < 2) begin
        d_idx[nd] = i;
        d_prod[nd] = bus.product;
        nd++;
      end
      if (nd == 2) begin
        bus.start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("b2b_first_product", 32'(d_prod[0]), 32'h023);
    chk("b2b_first_idx", 32'(d_idx[0]), 32'd7);
    chk("b2b_mid_product", 32'(mid_prod), 32'h023);
    chk("b2b_second_product", 32'(d_prod[1]), 32'h004);
    chk("b2b_second_idx", 32'(d_idx[1]), 32'd15);
    repeat (10) @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
    chk("b2b_held_product", 32'(bus.product), 32'h004);

    // Abort on the third RUN cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 6'd7;
    bus.multiplier = 6'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_busy_run", 32'(bus.busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy_drop", 32'(bus.busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    chk("abort_product_kept", 32'(bus.product), 32'h004);

    // Reset asserted mid-RUN, away from a clock edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 6'd4;
    bus.multiplier = 6'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_product", 32'(bus.product), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("midrst_stays_idle", 32'(cnt), 32'd0);
    run_case("m4_q4", 6'd4, 6'd4, 1'b0, 12'h010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
